// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder.
// Holds the instruction/address bus widths, the NOP encoding used for faulted
// fetches, the FSM state encodings and the response payload type.
// Optional feature macro used by the design: IMEM_FAULT_EN.
package imem_responder_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned CNT_W  = 4;

    localparam logic [INST_W-1:0] IMEM_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_WAIT = 2'd1,
        IMEM_RESP = 2'd2
    } imem_state_e;

    typedef struct packed {
        logic              err;
        logic [INST_W-1:0] inst;
    } imem_resp_t;

    // State entered on a request accept: a 1-cycle latency goes straight to RESP.
    function automatic imem_state_e accept_state(input int unsigned latency);
        return (latency == 1) ? IMEM_RESP : IMEM_WAIT;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Word-addressed instruction store.
// One loader write port and one synchronous read port; a read and a write to the
// same index in the same cycle return the old word. Contents are not reset.
// Ports:
//   clk        clock
//   wr_en_i    write enable
//   wr_idx_i   write word index
//   wr_data_i  write data
//   rd_en_i    read enable (loads the read hold register)
//   rd_idx_i   read word index
//   rd_data_o  read hold register
module imem_array
    import imem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 4096
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
    input  logic [INST_W-1:0]        wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
    output logic [INST_W-1:0]        rd_data_o
);

    logic [INST_W-1:0] mem_q [DEPTH];
    logic [INST_W-1:0] rd_data_q;

    // Both ports in one process: the read samples the pre-write array contents.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder between the core fetch stage and the memory model.
// Accepts one 64-bit fetch address over a valid/ready request channel and returns
// one 32-bit instruction over a valid/ready response channel LATENCY cycles after
// the accept edge. At most one request is outstanding.
// Optional feature: define IMEM_FAULT_EN to flag misaligned or out-of-range fetches
// with resp_err=1 and a NOP instruction; otherwise the index wraps and resp_err=0.
// Ports:
//   clk         clock, rising edge
//   rst         synchronous reset, active low
//   req_valid   fetch request valid
//   req_ready   request can be accepted this cycle
//   req_addr    fetch byte address
//   resp_valid  response valid
//   resp_ready  core accepts the response
//   resp_inst   fetched instruction
//   resp_err    fetch fault
//   ld_en       loader write enable
//   ld_idx      loader word index
//   ld_data     loader write data
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned       DEPTH     = 4096,
    parameter logic [63:0]       BASE_ADDR = 64'h8000_0000,
    parameter int unsigned       LATENCY   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [INST_W-1:0]        resp_inst,
    output logic                     resp_err,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_idx,
    input  logic [INST_W-1:0]        ld_data
);

    localparam int unsigned       IDX_W      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(LATENCY - 1);
    localparam imem_state_e       ACC_STATE  = accept_state(LATENCY);

    imem_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_hold_q, err_hold_d;
    imem_resp_t        last_q, last_d;
    imem_resp_t        cur_c;

    logic              accept_c;
    logic              fault_c;
    logic [IDX_W-1:0]  rd_idx_c;
    logic              rd_en_c;
    logic [INST_W-1:0] rd_data;

    // Handshake: a retiring response frees the slot in the same cycle.
    assign req_ready = (state_q == IMEM_IDLE) | ((state_q == IMEM_RESP) & resp_ready);
    assign accept_c  = req_valid & req_ready;

    // Address decode; the unsigned offset wraps below BASE_ADDR, so one compare
    // covers both ends of the window.
`ifdef IMEM_FAULT_EN
    logic [ADDR_W-1:0] offset_c;
    assign offset_c = req_addr - BASE_ADDR;
    assign fault_c  = (offset_c[1:0] != 2'b00) | (offset_c >= (ADDR_W'(DEPTH) << 2));
    assign rd_idx_c = offset_c[IDX_W+1:2];
`else
    assign fault_c  = 1'b0;
    assign rd_idx_c = IDX_W'((req_addr - BASE_ADDR) >> 2);
`endif

    // Faulted fetches leave the array untouched.
    assign rd_en_c = accept_c & ~fault_c;

    imem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk       (clk),
        .wr_en_i   (ld_en),
        .wr_idx_i  (ld_idx),
        .wr_data_i (ld_data),
        .rd_en_i   (rd_en_c),
        .rd_idx_i  (rd_idx_c),
        .rd_data_o (rd_data)
    );

    // Response carried by the hold registers of the outstanding request.
    always_comb begin
        cur_c.err  = err_hold_q;
        cur_c.inst = err_hold_q ? IMEM_NOP : rd_data;
    end

    // Next-state, counter and hold-register logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_hold_d = err_hold_q;
        last_d     = last_q;

        if (accept_c) begin
            err_hold_d = fault_c;
        end

        unique case (state_q)
            IMEM_IDLE: begin
                if (accept_c) begin
                    state_d = ACC_STATE;
                    cnt_d   = CNT_RELOAD;
                end
            end
            IMEM_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IMEM_RESP;
                end
            end
            IMEM_RESP: begin
                // Remember the presented response so it holds after retirement.
                last_d = cur_c;
                if (resp_ready) begin
                    if (accept_c) begin
                        state_d = ACC_STATE;
                        cnt_d   = CNT_RELOAD;
                    end else begin
                        state_d = IMEM_IDLE;
                    end
                end
            end
            default: begin
                state_d = IMEM_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IMEM_IDLE;
            cnt_q      <= '0;
            err_hold_q <= 1'b0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_hold_q <= err_hold_d;
            last_q     <= last_d;
        end
    end

    // In RESP the hold registers are presented; elsewhere the last response holds.
    assign resp_valid = (state_q == IMEM_RESP);
    assign resp_inst  = resp_valid ? cur_c.inst : last_q.inst;
    assign resp_err   = resp_valid ? cur_c.err  : last_q.err;

endmodule
